// File: rtl/psram_arb_pkg.sv
// Shared types and defaults for the two-master PSRAM arbiter.
package psram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 1024;

endpackage

// File: rtl/psram_arb_rr.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module psram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/psram_arb.sv
// Arbiter sharing one PSRAM controller port between two masters (core, DMA).
// Optional BUSY watchdog is built when PSRAM_ARB_TIMEOUT_EN is defined.
module psram_arb
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_valid_i,
    input  logic [31:0]       m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    input  logic [3:0]        m0_wstrb_i,
    output logic [31:0]       m0_rdata_o,
    output logic              m0_ready_o,
    input  logic              m1_valid_i,
    input  logic [31:0]       m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    input  logic [3:0]        m1_wstrb_i,
    output logic [31:0]       m1_rdata_o,
    output logic              m1_ready_o,
    output logic              s_valid_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [31:0]       s_wdata_o,
    output logic [3:0]        s_wstrb_o,
    input  logic [31:0]       s_rdata_i,
    input  logic              s_ready_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o,
    output state_t            state_o
);

    // Handshake: a master holds valid until it sees its ready for one cycle;
    // ready is only ever given to the registered owner while BUSY.
    state_t            state, state_nxt;
    logic [1:0]        req, win, owner;
    logic              last;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              done, forced;
    logic              unused_addr;

    assign req         = {m1_valid_i, m0_valid_i};
    assign unused_addr = ^{m0_addr_i[31:ADDR_W], m1_addr_i[31:ADDR_W]};

    psram_arb_rr u_rr (
        .req  (req),
        .last (last),
        .gnt  (win)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|req) state_nxt = BUSY;
            BUSY: if (done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured only on the IDLE->BUSY edge, so later master
    // activity cannot disturb an in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner   <= 2'b00;
            last    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state == IDLE && (|req)) begin
            owner   <= win;
            last    <= win[1];
            addr_q  <= win[1] ? m1_addr_i[ADDR_W-1:0] : m0_addr_i[ADDR_W-1:0];
            wdata_q <= win[1] ? m1_wdata_i : m0_wdata_i;
            wstrb_q <= win[1] ? m1_wstrb_i : m0_wstrb_i;
        end
    end

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    assign forced = (state == BUSY) && !s_ready_i &&
                    (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == BUSY && !done) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (forced) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_cfg;

    assign forced     = 1'b0;
    assign timeout_o  = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    assign done       = (state == BUSY) && (s_ready_i || forced);
    assign s_valid_o  = (state == BUSY);
    assign s_addr_o   = addr_q;
    assign s_wdata_o  = wdata_q;
    assign s_wstrb_o  = wstrb_q;
    assign grant_o    = s_valid_o ? owner : 2'b00;
    assign m0_ready_o = done && owner[0];
    assign m1_ready_o = done && owner[1];
    assign m0_rdata_o = forced ? 32'h0 : s_rdata_i;
    assign m1_rdata_o = forced ? 32'h0 : s_rdata_i;
    assign state_o    = state;

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb with a transaction-level reference model.
// Define PSRAM_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_psram_arb;

    localparam int ADDR_W = 24;
    localparam int TCYC   = 8;
`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_valid_i, m1_valid_i;
    logic [31:0]       m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]        m0_wstrb_i, m1_wstrb_i;
    logic [31:0]       m0_rdata_o, m1_rdata_o;
    logic              m0_ready_o, m1_ready_o;
    logic              s_valid_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [31:0]       s_wdata_o;
    logic [3:0]        s_wstrb_o;
    logic [31:0]       s_rdata_i = 32'hDEAD_BEEF;
    logic              s_ready_i = 1'b0;
    logic [1:0]        grant_o;
    logic              timeout_o;
    psram_arb_pkg::state_t dbg_state;

    psram_arb #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
        .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
        .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy    = 1'b0;
    int          m_owner   = 0;
    bit          m_last_m1 = 1'b1;
    logic [23:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [3:0]  m_wstrb   = '0;
    bit          m_timeout = 1'b0;
    int          m_cnt     = 0;

    function automatic bit m_forced();
        return TO_EN && m_busy && !s_ready_i && (m_cnt == TCYC - 1);
    endfunction

    function automatic bit m_done();
        return m_busy && (s_ready_i || m_forced());
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy = 0; m_owner = 0; m_last_m1 = 1; m_timeout = 0; m_cnt = 0;
            m_addr = '0; m_wdata = '0; m_wstrb = '0;
        end else if (m_busy) begin
            if (m_done()) begin
                if (m_forced()) m_timeout = 1;
                m_busy = 0;
            end else begin
                m_cnt++;
            end
        end else if (m0_valid_i || m1_valid_i) begin
            if (m0_valid_i && m1_valid_i) m_owner = m_last_m1 ? 0 : 1;
            else                          m_owner = m0_valid_i ? 0 : 1;
            m_addr    = (m_owner == 0) ? m0_addr_i[23:0] : m1_addr_i[23:0];
            m_wdata   = (m_owner == 0) ? m0_wdata_i : m1_wdata_i;
            m_wstrb   = (m_owner == 0) ? m0_wstrb_i : m1_wstrb_i;
            m_last_m1 = (m_owner == 1);
            m_busy    = 1;
            m_cnt     = 0;
        end
    end

    // ---------------- compare process + bookkeeping ----------------
    int          served_q[$];
    int          m0_pulses = 0;
    int          run_len = 0, last_len = 0;
    logic [31:0] last_rdata0 = '0, last_rdata1 = '0;
    logic [23:0] last_addr = '0;

    always @(negedge clk_i) begin
        chk("s_valid", s_valid_o, m_busy);
        chk("grant", grant_o, m_busy ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00);
        chk("m0_ready", m0_ready_o, m_done() && m_owner == 0);
        chk("m1_ready", m1_ready_o, m_done() && m_owner == 1);
        chk("timeout", timeout_o, m_timeout);
        chk("state", dbg_state == psram_arb_pkg::BUSY, m_busy);
        if (m_busy) begin
            chk("s_addr", s_addr_o, m_addr);
            chk("s_wdata", s_wdata_o, m_wdata);
            chk("s_wstrb", s_wstrb_o, m_wstrb);
        end
        if (!rst_i) begin
            chk("m0_rdata", m0_rdata_o, m_forced() ? 32'h0 : s_rdata_i);
            chk("m1_rdata", m1_rdata_o, m_forced() ? 32'h0 : s_rdata_i);
        end
        run_len = s_valid_o ? run_len + 1 : 0;
        if (m0_ready_o) begin
            served_q.push_back(0); m0_pulses++;
            last_rdata0 = m0_rdata_o; last_len = run_len; last_addr = s_addr_o;
        end
        if (m1_ready_o) begin
            served_q.push_back(1);
            last_rdata1 = m1_rdata_o; last_len = run_len; last_addr = s_addr_o;
        end
    end

    // ---------------- PSRAM responder ----------------
    bit          resp_en    = 1'b1;
    int          resp_delay = 0;
    logic [31:0] resp_data  = 32'h0;
    int          resp_cnt   = 0;

    initial forever begin
        @(posedge clk_i);
        #1;
        if (s_valid_o) begin
            resp_cnt++;
            s_ready_i = resp_en && (resp_cnt > resp_delay);
            s_rdata_i = s_ready_i ? resp_data : 32'hDEAD_BEEF;
        end else begin
            resp_cnt  = 0;
            s_ready_i = 1'b0;
            s_rdata_i = 32'hDEAD_BEEF;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_valid_i = v; m0_addr_i = a; m0_wdata_i = d; m0_wstrb_i = s;
        end else begin
            m1_valid_i = v; m1_addr_i = a; m1_wdata_i = d; m1_wstrb_i = s;
        end
    endtask

    task automatic master_req(input int m, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit scramble, input bit keep);
        int n;
        bit seen;
        drive(m, 1'b1, a, d, s);
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk_i);
            if ((m == 0 && m0_ready_o) || (m == 1 && m1_ready_o)) begin
                seen = 1;
            end else if (scramble && grant_o[m]) begin
                #1;
                if (m == 0) m0_addr_i = 32'hFFFF_FFFF;
                else        m1_addr_i = 32'hFFFF_FFFF;
            end
            n++;
        end
        chk("req_completed", seen, 1'b1);
        @(posedge clk_i);
        #2;
        if (!keep) begin
            if (m == 0) m0_valid_i = 1'b0;
            else        m1_valid_i = 1'b0;
        end
    endtask

    task automatic master_stream(input int m, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            master_req(m, base + 32'(i * 4), base ^ 32'(i), 4'hF, 1'b0, i < n - 1);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // ---------------- stimulus ----------------
    int p0;
    int exp_order[4];

    initial begin
        rst_i = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        cycles(2);
        chk("rst_s_valid", s_valid_o, 1'b0);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_ready", {m1_ready_o, m0_ready_o}, 2'b00);
        chk("rst_timeout", timeout_o, 1'b0);
        chk("rst_req_regs", {s_addr_o, s_wdata_o, s_wstrb_o}, 60'h0);
        rst_i = 1'b0;
        cycles(1);

        // single m0 write, ready on the fourth BUSY cycle
        resp_delay = 3;
        p0 = m0_pulses;
        fork
            master_req(0, 32'h10, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0);
            begin
                @(negedge clk_i);
                chk("t1_no_valid_yet", s_valid_o, 1'b0);
                @(negedge clk_i);
                chk("t1_valid_next", s_valid_o, 1'b1);
                chk("t1_grant", grant_o, 2'b01);
                chk("t1_addr", s_addr_o, 24'h10);
                chk("t1_wdata", s_wdata_o, 32'hA5A5_A5A5);
            end
        join
        chk("t1_pulses", m0_pulses - p0, 1);
        chk("t1_busy_len", last_len, 4);
        cycles(2);

        // repeated ties after a fresh reset alternate m0,m1,m0,m1
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        cycles(1);
        resp_delay = 1;
        served_q.delete();
        fork
            master_stream(0, 32'h100, 2);
            master_stream(1, 32'h200, 2);
        join
        exp_order = '{0, 1, 0, 1};
        chk("t2_count", served_q.size(), 4);
        for (int i = 0; i < 4 && i < served_q.size(); i++) begin
            chk("t2_order", served_q[i], exp_order[i]);
        end
        cycles(2);

        // m1 read returns rdata in the ready cycle
        resp_delay = 0;
        resp_data  = 32'h1234_5678;
        p0 = m0_pulses;
        master_req(1, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("t3_rdata", last_rdata1, 32'h1234_5678);
        chk("t3_m0_quiet", m0_pulses - p0, 0);
        cycles(2);

        // address changed after grant is not seen downstream
        resp_delay = 2;
        master_req(0, 32'h0000_0200, 32'h1, 4'h3, 1'b1, 1'b0);
        chk("t4_addr_held", last_addr, 24'h200);
        cycles(2);

        // asynchronous reset in the middle of a transaction
        resp_en = 1'b0;
        p0 = m0_pulses;
        drive(0, 1'b1, 32'h400, 32'h5, 4'h1);
        cycles(2);
        chk("t5_busy", s_valid_o, 1'b1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_async_valid", s_valid_o, 1'b0);
        chk("t5_async_grant", grant_o, 2'b00);
        chk("t5_async_ready", m0_ready_o, 1'b0);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycles(1);
        rst_i = 1'b0;
        cycles(2);
        chk("t5_no_pulse", m0_pulses - p0, 0);
        chk("t5_idle", s_valid_o, 1'b0);
        resp_en = 1'b1;

`ifdef PSRAM_ARB_TIMEOUT_EN
        // watchdog completes on BUSY cycle TCYC with zero data
        resp_en = 1'b0;
        master_req(0, 32'h500, 32'h7, 4'hF, 1'b0, 1'b0);
        chk("t6_busy_len", last_len, TCYC);
        chk("t6_rdata_zero", last_rdata0, 32'h0);
        chk("t6_timeout_set", timeout_o, 1'b1);
        cycles(3);
        chk("t6_timeout_sticky", timeout_o, 1'b1);
        resp_en = 1'b1;
`else
        chk("t6_timeout_tied", timeout_o, 1'b0);
`endif

        cycles(2);
        summary();
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        summary();
        $finish;
    end

endmodule

// File: doc/psram_arb.md
PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning address bits forwarded to the PSRAM port.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, meaning BUSY cycles before a forced completion (used only with PSRAM_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports m0_valid_i (in, 1), m0_addr_i (in, 32), m0_wdata_i (in, 32), m0_wstrb_i (in, 4), m0_rdata_o (out, 32), m0_ready_o (out, 1); these form requester 0, the core data path.
REQ-006 SHALL have the same six ports prefixed m1_, forming requester 1, the DMA/secondary master.
REQ-007 SHALL have ports s_valid_o (out, 1), s_addr_o (out, ADDR_W), s_wdata_o (out, 32), s_wstrb_o (out, 4), s_rdata_i (in, 32), s_ready_i (in, 1); these form the single PSRAM controller port.
REQ-008 SHALL have port grant_o, out, 2, one-hot current owner; 2'b00 when idle.
REQ-009 SHALL have port timeout_o, out, 1, sticky timeout flag.

Function
REQ-010 SHALL implement states IDLE and BUSY.
REQ-011 In IDLE with any mN_valid_i high, SHALL select a winner, register its addr[ADDR_W-1:0]/wdata/wstrb, set grant_o, and enter BUSY on the next edge.
REQ-012 On simultaneous requests, SHALL grant the requester not served last (round-robin); after reset, last-served = m1, so m0 wins the first tie.
REQ-013 In BUSY, s_valid_o SHALL be 1 and s_addr_o/s_wdata_o/s_wstrb_o SHALL come from the registered request, independent of later master inputs.
REQ-014 In BUSY with s_ready_i=1, the owner's mN_ready_o SHALL be 1 in that same cycle (combinational), and the FSM SHALL return to IDLE on the next edge.
REQ-015 The non-owner ready SHALL be 0; m0_rdata_o and m1_rdata_o SHALL both equal s_rdata_i.
REQ-016 Latency SHALL be valid→s_valid_o one cycle; a mandatory one-cycle IDLE bubble SHALL separate consecutive transactions.
REQ-017 A request whose valid drops before grant SHALL be ignored; once registered, the transaction SHALL complete even if the owner drops valid.
REQ-018 s_valid_o SHALL be 0 in IDLE.

Reset
REQ-019 Reset SHALL force: state IDLE; s_valid_o=0; grant_o=0; mN_ready_o=0; timeout_o=0; last-served=m1; request registers 0.
REQ-020 Reset asserted mid-transaction SHALL abort it immediately (asynchronously), and no ready SHALL be issued.

Configuration
REQ-021 With PSRAM_ARB_TIMEOUT_EN defined, a BUSY cycle counter SHALL run; if it reaches TIMEOUT_CYC-1 without s_ready_i, the arbiter SHALL assert the owner's ready for one cycle with rdata forced to 32'h0, set timeout_o (cleared only by reset), and return to IDLE.
REQ-022 Without PSRAM_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely, no counter SHALL exist, and timeout_o SHALL be tied to 0.

Structure
REQ-023 Package psram_arb_pkg SHALL hold the state enum typedef and the default TIMEOUT_CYC constant.
REQ-024 The two-way round-robin picker SHALL be the sub-module psram_arb_rr (inputs: req[1:0], last; output: one-hot gnt).

Verification
REQ-025 m0 write alone (addr 0x10, wdata 0xA5A5A5A5, wstrb 4'hF), s_ready_i after 3 cycles -> s_valid_o from cycle+1, m0_ready_o pulses exactly once, grant_o=01.
REQ-026 m0 and m1 valid in the same cycle after reset -> m0 served first, then m1 after one IDLE bubble; repeated ties alternate.
REQ-027 m1 read, s_rdata_i=0x12345678 with ready -> m1_ready_o=1 and m1_rdata_o=0x12345678 in the same cycle; m0_ready_o stays 0.
REQ-028 m0 changes addr after grant -> s_addr_o holds the granted address until completion.
REQ-029 rst_i pulse while BUSY -> s_valid_o and grant_o go 0 without waiting for an edge; no ready pulse.
REQ-030 With PSRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, s_ready_i held 0 -> owner ready with rdata 0 on BUSY cycle 8; timeout_o stays 1.
